multicycle_control_fsm: RTL and testbench

- Main control state machine for the multi-cycle MIPS core.
- Sits directly upstream of the instruction fetch unit and drives its PC_LOAD, IorD, IR_EN and PC_SEL.
- Also drives the register file, RAM write enable and ALU operand/operation selects.
- Decodes OPCODE/FUNCT from the instruction register output and sequences each instruction over 3–5 cycles.

---
 rtl/multicycle_control_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
// Main control state machine of the multi-cycle MIPS core. Decodes OPCODE and
// FUNCT from the instruction register and sequences each instruction over
// 3-5 cycles, driving the fetch unit, register file, RAM and ALU selects.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset (state returns to FETCH)
//   OPCODE      Instr[31:26]
//   FUNCT       Instr[5:0]
//   ZERO        ALU zero flag (combinational, used only in BR_EX)
//   PC_LOAD     PC register enable
//   IorD        memory address select (0 PC, 1 ALU_OUT)
//   IR_EN       instruction register enable
//   PC_SEL      next-PC select (0 ALU_OUT, 1 ALU_REG_OUT, 2 jump, 3 Reg1, 4 zero)
//   MEM_WE      RAM write enable
//   REG_WE      register file write enable
//   REG_DST     write register select (00 rt, 01 rd, 10 r31)
//   MEM_TO_REG  write-back select (00 ALU_REG_OUT, 01 MDR, 10 PC_OUT)
//   ALU_SRC_A   ALU A select (0 PC, 1 reg A)
//   ALU_SRC_B   ALU B select (00 reg B, 01 4, 10 imm, 11 imm<<2)
//   ALU_CTRL    ALU operation
//   ILLEGAL_OP  high for the single cycle spent in EXC
//   STATE_OUT   current state (debug)
//
// Outputs are decoded from the state register alone so that an asynchronous
// reset drops every write enable immediately; the only input-dependent terms
// are PC_LOAD in BR_EX (ZERO, OPCODE) and ALU_CTRL in R_EX (FUNCT).
// ----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int unsigned STATE_WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [5:0]             OPCODE,
    input  logic [5:0]             FUNCT,
    input  logic                   ZERO,
    output logic                   PC_LOAD,
    output logic                   IorD,
    output logic                   IR_EN,
    output logic [2:0]             PC_SEL,
    output logic                   MEM_WE,
    output logic                   REG_WE,
    output logic [1:0]             REG_DST,
    output logic [1:0]             MEM_TO_REG,
    output logic                   ALU_SRC_A,
    output logic [1:0]             ALU_SRC_B,
    output logic [2:0]             ALU_CTRL,
    output logic                   ILLEGAL_OP,
    output logic [STATE_WIDTH-1:0] STATE_OUT
);

    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH   = STATE_WIDTH'(0),
        S_DECODE  = STATE_WIDTH'(1),
        S_MEM_ADR = STATE_WIDTH'(2),
        S_MEM_RD  = STATE_WIDTH'(3),
        S_MEM_WB  = STATE_WIDTH'(4),
        S_MEM_WR  = STATE_WIDTH'(5),
        S_R_EX    = STATE_WIDTH'(6),
        S_R_WB    = STATE_WIDTH'(7),
        S_BR_EX   = STATE_WIDTH'(8),
        S_ADDI_EX = STATE_WIDTH'(9),
        S_ADDI_WB = STATE_WIDTH'(10),
        S_J_EX    = STATE_WIDTH'(11),
        S_JAL_EX  = STATE_WIDTH'(12),
        S_JR_EX   = STATE_WIDTH'(13),
        S_EXC     = STATE_WIDTH'(14),
        S_UNUSED  = STATE_WIDTH'(15)
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    state_e r_state;
    state_e w_next;
    logic   w_funct_arith;
    logic [2:0] w_funct_alu;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // FUNCT decode shared by the DECODE dispatch and the R_EX ALU op
    always_comb begin
        w_funct_arith = 1'b1;
        w_funct_alu   = ALU_ADD;
        case (FUNCT)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: w_funct_arith = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_LW, OP_SW:   w_next = S_MEM_ADR;
                    OP_RTYPE: begin
                        if (FUNCT == FN_JR) begin
                            w_next = S_JR_EX;
                        end else if (w_funct_arith) begin
                            w_next = S_R_EX;
                        end else begin
                            w_next = S_EXC;
                        end
                    end
                    OP_BEQ, OP_BNE: w_next = S_BR_EX;
                    OP_ADDI:        w_next = S_ADDI_EX;
                    OP_J:           w_next = S_J_EX;
                    OP_JAL:         w_next = S_JAL_EX;
                    default:        w_next = S_EXC;
                endcase
            end
            // Only lw and sw reach MEM_ADR, so anything other than lw is a store
            S_MEM_ADR: w_next = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  w_next = S_MEM_WB;
            S_R_EX:    w_next = S_R_WB;
            S_ADDI_EX: w_next = S_ADDI_WB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        PC_LOAD    = 1'b0;
        IorD       = 1'b0;
        IR_EN      = 1'b0;
        PC_SEL     = 3'd0;
        MEM_WE     = 1'b0;
        REG_WE     = 1'b0;
        REG_DST    = 2'b00;
        MEM_TO_REG = 2'b00;
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = 2'b00;
        ALU_CTRL   = 3'b000;
        ILLEGAL_OP = 1'b0;
        case (r_state)
            S_FETCH: begin
                IR_EN     = 1'b1;
                ALU_SRC_B = 2'b01;
                ALU_CTRL  = ALU_ADD;
                PC_LOAD   = 1'b1;
            end
            S_DECODE: begin
                ALU_SRC_B = 2'b11;
                ALU_CTRL  = ALU_ADD;
            end
            S_MEM_ADR, S_ADDI_EX: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = 2'b10;
                ALU_CTRL  = ALU_ADD;
            end
            S_MEM_RD: IorD = 1'b1;
            S_MEM_WB: begin
                REG_WE     = 1'b1;
                MEM_TO_REG = 2'b01;
            end
            S_MEM_WR: begin
                IorD   = 1'b1;
                MEM_WE = 1'b1;
            end
            S_R_EX: begin
                ALU_SRC_A = 1'b1;
                ALU_CTRL  = w_funct_alu;
            end
            S_R_WB: begin
                REG_WE  = 1'b1;
                REG_DST = 2'b01;
            end
            // beq takes the branch on ZERO, bne on its complement
            S_BR_EX: begin
                ALU_SRC_A = 1'b1;
                ALU_CTRL  = ALU_SUB;
                PC_SEL    = 3'd1;
                PC_LOAD   = (OPCODE == OP_BNE) ? ~ZERO : ZERO;
            end
            S_ADDI_WB: REG_WE = 1'b1;
            S_J_EX: begin
                PC_SEL  = 3'd2;
                PC_LOAD = 1'b1;
            end
            // r31 captures PC_OUT (already PC+4) on the same edge the PC jumps
            S_JAL_EX: begin
                PC_SEL     = 3'd2;
                PC_LOAD    = 1'b1;
                REG_WE     = 1'b1;
                REG_DST    = 2'b10;
                MEM_TO_REG = 2'b10;
            end
            S_JR_EX: begin
                PC_SEL  = 3'd3;
                PC_LOAD = 1'b1;
            end
            S_EXC: begin
                PC_SEL     = 3'd4;
                PC_LOAD    = 1'b1;
                ILLEGAL_OP = 1'b1;
            end
            default: ;
        endcase
    end

    assign STATE_OUT = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Drives instruction opcodes through the control FSM and compares every
// cycle's full output vector against a per-instruction-class reference model.
// ----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] OPCODE = 6'd0;
    logic [5:0] FUNCT = 6'd0;
    logic       ZERO = 1'b0;
    logic       PC_LOAD, IorD, IR_EN, MEM_WE, REG_WE, ALU_SRC_A, ILLEGAL_OP;
    logic [2:0] PC_SEL, ALU_CTRL;
    logic [1:0] REG_DST, MEM_TO_REG, ALU_SRC_B;
    logic [3:0] STATE_OUT;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    multicycle_control_fsm #(.STATE_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
        .PC_LOAD(PC_LOAD), .IorD(IorD), .IR_EN(IR_EN), .PC_SEL(PC_SEL),
        .MEM_WE(MEM_WE), .REG_WE(REG_WE), .REG_DST(REG_DST),
        .MEM_TO_REG(MEM_TO_REG), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
        .ALU_CTRL(ALU_CTRL), .ILLEGAL_OP(ILLEGAL_OP), .STATE_OUT(STATE_OUT)
    );

    always #5 CLK = ~CLK;

    typedef enum int {C_LW, C_SW, C_RT, C_BEQ, C_BNE, C_ADDI, C_J, C_JAL, C_JR, C_ILL} cls_e;

    typedef struct packed {
        logic       pc_load;
        logic       iord;
        logic       ir_en;
        logic [2:0] pc_sel;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mtr;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] ctrl;
        logic       ill;
        logic [3:0] st;
    } obs_t;

    obs_t got;
    assign got = {PC_LOAD, IorD, IR_EN, PC_SEL, MEM_WE, REG_WE, REG_DST,
                  MEM_TO_REG, ALU_SRC_A, ALU_SRC_B, ALU_CTRL, ILLEGAL_OP, STATE_OUT};

    function automatic cls_e classify(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h04: return C_BEQ;
            6'h05: return C_BNE;
            6'h08: return C_ADDI;
            6'h02: return C_J;
            6'h03: return C_JAL;
            6'h00: begin
                if (fn == 6'h08) return C_JR;
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) return C_RT;
                return C_ILL;
            end
            default: return C_ILL;
        endcase
    endfunction

    function automatic int cycles_of(cls_e c);
        case (c)
            C_LW:                return 5;
            C_SW, C_RT, C_ADDI:  return 4;
            default:             return 3;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    // Expected outputs for cycle 'step' of an instruction of class c
    function automatic obs_t expect_at(cls_e c, int step, logic [5:0] fn, logic z);
        obs_t e = '0;
        if (step == 0) begin
            e.ir_en = 1'b1; e.src_b = 2'b01; e.ctrl = 3'b010; e.pc_load = 1'b1; e.st = 4'd0;
        end else if (step == 1) begin
            e.src_b = 2'b11; e.ctrl = 3'b010; e.st = 4'd1;
        end else begin
            case (c)
                C_LW, C_SW: begin
                    if (step == 2) begin
                        e.src_a = 1'b1; e.src_b = 2'b10; e.ctrl = 3'b010; e.st = 4'd2;
                    end else if (c == C_SW) begin
                        e.iord = 1'b1; e.mem_we = 1'b1; e.st = 4'd5;
                    end else if (step == 3) begin
                        e.iord = 1'b1; e.st = 4'd3;
                    end else begin
                        e.reg_we = 1'b1; e.mtr = 2'b01; e.st = 4'd4;
                    end
                end
                C_RT: begin
                    if (step == 2) begin
                        e.src_a = 1'b1; e.ctrl = alu_of(fn); e.st = 4'd6;
                    end else begin
                        e.reg_we = 1'b1; e.reg_dst = 2'b01; e.st = 4'd7;
                    end
                end
                C_BEQ, C_BNE: begin
                    e.src_a = 1'b1; e.ctrl = 3'b110; e.pc_sel = 3'd1; e.st = 4'd8;
                    e.pc_load = (c == C_BEQ) ? z : !z;
                end
                C_ADDI: begin
                    if (step == 2) begin
                        e.src_a = 1'b1; e.src_b = 2'b10; e.ctrl = 3'b010; e.st = 4'd9;
                    end else begin
                        e.reg_we = 1'b1; e.st = 4'd10;
                    end
                end
                C_J:   begin e.pc_sel = 3'd2; e.pc_load = 1'b1; e.st = 4'd11; end
                C_JAL: begin
                    e.pc_sel = 3'd2; e.pc_load = 1'b1; e.reg_we = 1'b1;
                    e.reg_dst = 2'b10; e.mtr = 2'b10; e.st = 4'd12;
                end
                C_JR:  begin e.pc_sel = 3'd3; e.pc_load = 1'b1; e.st = 4'd13; end
                default: begin e.pc_sel = 3'd4; e.pc_load = 1'b1; e.ill = 1'b1; e.st = 4'd14; end
            endcase
        end
        return e;
    endfunction

    // Runs one instruction starting in FETCH, just after a falling edge.
    // zsel: 0/1 fixed ZERO, 2 random. max_steps < 0 runs the whole instruction
    // and leaves the bench at the next FETCH; otherwise it stops mid-instruction.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int zsel, input int max_steps);
        cls_e c;
        int   n;
        obs_t want;
        c = classify(op, fn);
        n = cycles_of(c);
        if (max_steps >= 0 && max_steps < n) n = max_steps;
        OPCODE = op;
        FUNCT  = fn;
        for (int s = 0; s < n; s++) begin
            if (s > 0) @(negedge CLK);
            ZERO = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            #1;
            want = expect_at(c, s, fn, ZERO);
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL %s op=%h fn=%h step=%0d got=%h want=%h",
                         tag, op, fn, s, got, want);
            end
        end
        if (max_steps < 0) @(negedge CLK);
    endtask

    task automatic test_reset();
        obs_t want;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (STATE_OUT !== 4'd0 || MEM_WE !== 1'b0 || REG_WE !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold state=%0d mem_we=%b reg_we=%b want 0/0/0",
                     STATE_OUT, MEM_WE, REG_WE);
        end
        RST = 1'b1;
        #1;
        want = expect_at(C_ILL, 0, 6'd0, 1'b0);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL reset_release got=%h want=%h", got, want);
        end
    endtask

    task automatic test_lw();
        run_instr("lw", 6'h23, 6'($urandom), 2, -1);
        run_instr("sw", 6'h2b, 6'($urandom), 2, -1);
    endtask

    task automatic test_rtype();
        run_instr("r_sub", 6'h00, 6'h22, 2, -1);
        run_instr("r_add", 6'h00, 6'h20, 2, -1);
        run_instr("r_and", 6'h00, 6'h24, 2, -1);
        run_instr("r_or",  6'h00, 6'h25, 2, -1);
        run_instr("r_slt", 6'h00, 6'h2a, 2, -1);
        run_instr("addi",  6'h08, 6'($urandom), 2, -1);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 6'h04, 6'($urandom), 1, -1);
        run_instr("beq_z0", 6'h04, 6'($urandom), 0, -1);
        run_instr("bne_z0", 6'h05, 6'($urandom), 0, -1);
        run_instr("bne_z1", 6'h05, 6'($urandom), 1, -1);
    endtask

    task automatic test_jumps();
        run_instr("j",   6'h02, 6'($urandom), 2, -1);
        run_instr("jal", 6'h03, 6'($urandom), 2, -1);
        run_instr("jr",  6'h00, 6'h08, 2, -1);
    endtask

    task automatic test_illegal();
        run_instr("ill_op", 6'h3f, 6'($urandom), 2, -1);
        run_instr("ill_fn", 6'h00, 6'h07, 2, -1);
    endtask

    task automatic test_reset_abort();
        run_instr("sw_abort", 6'h2b, 6'd0, 2, 4);
        #1 RST = 1'b0;
        #1;
        n_checks++;
        if (STATE_OUT !== 4'd0 || MEM_WE !== 1'b0 || REG_WE !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_abort state=%0d mem_we=%b reg_we=%b want 0/0/0",
                     STATE_OUT, MEM_WE, REG_WE);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        run_instr("after_abort", 6'h23, 6'd0, 2, -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [9] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03, 6'h00};
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};
        logic [5:0] op, fn;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr("random", op, fn, 2, -1);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
